uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_tx_queue.sv | 123 ++++++++++++
 tb/tb_uart_tx_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit path: FSM state encoding and the default byte width.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers; rd_data shows the head entry without a read latency.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_fire, rd_fire;

    // The extra MSB tells a full buffer apart from an empty one when the addresses match.
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_fire  = wr_en && !full;
        rd_fire  = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_fire};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_fire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of a UART transmitter: buffers writes and hands bytes over with a start strobe.
// Define UART_TX_QUEUE_CRLF_EN to expand each popped LF into CR followed by LF.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [DATA_WIDTH-1:0]  datatx,
    output logic                   start,
    input  logic                   ready,
    output logic                   busy
);

    tx_state_e             state_q, state_d;
    logic                  start_q, start_d;
    logic [DATA_WIDTH-1:0] datatx_q, datatx_d;
    logic                  overflow_q, overflow_d;
    logic                  pop;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

`ifdef UART_TX_QUEUE_CRLF_EN
    localparam logic [DATA_WIDTH-1:0] LF = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CR = DATA_WIDTH'(8'h0D);
    logic lf_pend_q, lf_pend_d;
`endif

    sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_en  (pop),
        .rd_data(fifo_rd_data),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        datatx_d   = datatx_q;
        pop        = 1'b0;
        start_d    = (state_q == START);
        overflow_d = overflow_q;
        if (ovf_clr) overflow_d = 1'b0;
        if (wr_en && full) overflow_d = 1'b1;
`ifdef UART_TX_QUEUE_CRLF_EN
        lf_pend_d  = lf_pend_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef UART_TX_QUEUE_CRLF_EN
                // A held LF goes out before anything else is popped.
                if (lf_pend_q && ready) begin
                    datatx_d  = LF;
                    lf_pend_d = 1'b0;
                    state_d   = START;
                end else if (!empty && ready) begin
                    pop     = 1'b1;
                    state_d = START;
                    if (fifo_rd_data == LF) begin
                        datatx_d  = CR;
                        lf_pend_d = 1'b1;
                    end else begin
                        datatx_d  = fifo_rd_data;
                    end
                end
`else
                if (!empty && ready) begin
                    pop      = 1'b1;
                    datatx_d = fifo_rd_data;
                    state_d  = START;
                end
`endif
            end
            START:     state_d = WAIT_ACK;
            WAIT_ACK:  if (!ready) state_d = WAIT_DONE;
            WAIT_DONE: if (ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            datatx_q   <= '0;
            overflow_q <= 1'b0;
`ifdef UART_TX_QUEUE_CRLF_EN
            lf_pend_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            datatx_q   <= datatx_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_QUEUE_CRLF_EN
            lf_pend_q  <= lf_pend_d;
`endif
        end
    end

    assign start    = start_q;
    assign datatx   = datatx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: a UART model answers start strobes, a monitor checks byte order.
module tb_uart_tx_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [DW-1:0]          wr_data;
    logic                   wr_en;
    logic                   full, empty, overflow, start, busy;
    logic [$clog2(DEPTH):0] count;
    logic                   ovf_clr;
    logic [DW-1:0]          datatx;
    logic                   ready = 1'b1;

    int  n_checks = 0;
    int  n_errors = 0;
    int  strobes  = 0;
    int  uart_cnt = 0;
    int  uart_busy_len = 100;
    bit  uart_hold = 1'b0;
    logic [7:0] exp_q[$];

    uart_tx_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .ovf_clr (ovf_clr),
        .datatx  (datatx),
        .start   (start),
        .ready   (ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the UART sees bytes in write order, LF expanded to CR LF when enabled.
    function automatic void push_exp(input logic [7:0] b);
`ifdef UART_TX_QUEUE_CRLF_EN
        if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(b);
    endfunction

    // UART model: accepts a strobe while idle, then reports busy for uart_busy_len cycles.
    always begin
        @(negedge clk);
        #1;
        if (uart_cnt > 0) uart_cnt--;
        else if (start && ready) uart_cnt = uart_busy_len;
        ready = !(uart_hold || uart_cnt > 0);
    end

    // Monitor: compares every strobed byte against the head of the expected queue.
    logic          prev_start = 1'b0;
    logic          prev_busy  = 1'b0;
    logic [DW-1:0] prev_datatx = '0;
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset) begin
            if (start) begin
                strobes++;
                check("start_not_consecutive", prev_start, 0);
                check("start_while_busy", busy, 1);
                if (exp_q.size() == 0) begin
                    check("tx_unexpected_start", start, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", datatx, e);
                end
            end
            if (busy && prev_busy) check("datatx_stable", datatx, prev_datatx);
        end
        prev_start  = start;
        prev_busy   = busy;
        prev_datatx = datatx;
    end

    task automatic write_byte(input logic [7:0] d, input bit accepted);
        wr_data = d;
        wr_en   = 1'b1;
        if (accepted) push_exp(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || busy || !ready) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_all_sent", exp_q.size(), 0);
        check("drain_idle", busy, 0);
        check("drain_empty", empty, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_strobes;
        int exp_n;
        bit busy_ok;
        logic [7:0] d;

        reset = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_datatx", datatx, 0);
        reset = 1'b0;

        // Latency: strobe exactly two cycles after the edge that samples the write.
        uart_busy_len = 100;
        write_byte(8'h55, 1);
        check("lat_edge0_start", start, 0);
        @(negedge clk);
        check("lat_edge1_start", start, 0);
        @(negedge clk);
        check("lat_edge2_start", start, 1);
        check("lat_datatx", datatx, 8'h55);
        n = 0;
        while (ready && n < 10) begin @(negedge clk); n++; end
        check("uart_ack_seen", ready, 0);
        busy_ok = 1'b1;
        n = 0;
        while (!ready && n < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("busy_while_uart_busy", busy_ok, 1);
        check("uart_returned", ready, 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);

        // Fill to full with the UART held off, then overflow behaviour.
        uart_busy_len = 5;
        uart_hold = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i), 1);
        check("fill_full", full, 1);
        check("fill_count", count, DEPTH);
        check("fill_empty", empty, 0);
        check("fill_no_ovf", overflow, 0);
        write_byte(8'hAA, 0);
        check("ovf_set", overflow, 1);
        check("ovf_count_kept", count, DEPTH);
        ovf_clr = 1'b1;
        write_byte(8'hAB, 0);
        ovf_clr = 1'b0;
        check("ovf_set_beats_clear", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        base_strobes = strobes;
        exp_n = exp_q.size();
        uart_hold = 1'b0;
        write_byte(8'hAC, 0);
        check("ovf_full_with_pop", overflow, 1);
        check("count_after_pop", count, DEPTH - 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared2", overflow, 0);
        wait_drain(1000);
        check("drain_strobe_count", strobes - base_strobes, exp_n);

        // Pointer wrap-around.
        for (int i = 16; i < 20; i++) write_byte(8'(i), 1);
        wait_drain(500);

        // Simultaneous write and pop at count 5.
        uart_hold = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) write_byte(8'h20 + 8'(i), 1);
        check("five_count", count, 5);
        uart_hold = 1'b0;
        write_byte(8'h25, 1);
        check("wr_pop_count", count, 5);
        wait_drain(500);

        // Reset while WAIT_DONE with three bytes queued.
        uart_busy_len = 40;
        for (int i = 0; i < 4; i++) write_byte(8'h30 + 8'(i), 1);
        repeat (8) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_uart", ready, 0);
        check("pre_rst_count", count, 3);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_start", start, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_count", count, 0);
        check("mid_rst_idle", busy, 0);
        check("mid_rst_datatx", datatx, 0);
        exp_q.delete();
        reset = 1'b0;
        write_byte(8'h31, 1);
        wait_drain(500);

        // Line-feed handling.
        uart_busy_len = 3;
        write_byte(8'h41, 1);
        write_byte(8'h0A, 1);
        wait_drain(500);

        // Randomised bursts, each no longer than the queue so every write is accepted.
        for (int b = 0; b < 20; b++) begin
            uart_busy_len = int'($urandom_range(1, 6));
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) begin
                d = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
                write_byte(d, 1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_drain(2000);
            check("rand_no_ovf", overflow, 0);
            check("rand_count_zero", count, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
